mem_responder: RTL and testbench
================================

# mem_responder

Single-array memory responder for the CPU's instruction and data request ports; it is the memory side of the `read`/`write`/`resp` handshake that the processor top drives. Sits directly below the processor top in simulation and FPGA bring-up builds, standing in for the I/D caches. Arbitrates the two ports onto one byte-writable word array and answers each request with a one-cycle `resp` pulse after a fixed latency.

## Interface
- `ADDR_WIDTH`, 10: word-index bits. The array holds 2^ADDR_WIDTH 32-bit words.
- `LATENCY`, 2: cycles from grant to `resp`. Legal range is 1..15.

- `clk` in 1: sole clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-low reset. Asserted when 0.
- `inst_read` in 1: instruction read request. Held until `inst_resp`.
- `inst_addr` in 32: instruction byte address.
- `inst_resp` out 1: one-cycle completion pulse for the instruction port.
- `inst_rdata` out 32: instruction read data.
- `data_read` in 1: data read request.
- `data_write` in 1: data write request.
- `data_mbe` in 4: byte enables. Bit i enables byte lane i, i.e. bits [8i+7:8i].
- `data_addr` in 32: data byte address.
- `data_wdata` in 32: write data.
- `data_resp` out 1: one-cycle completion pulse for the data port.
- `data_rdata` out 32: data read data.

## Operation
- Word index is `addr[ADDR_WIDTH+1:2]`.
  - Bits [1:0] are ignored.
  - Upper bits are ignored, so addresses alias.
- FSM states:
  - `IDLE`: samples requests.
  - `BUSY_I`: serving the instruction port.
  - `BUSY_D`: serving the data port.
- Arbitration in `IDLE`:
  - Only one port requesting: that port is granted.
  - Both ports requesting: the port NOT granted last time wins. `last_grant` resets to instruction, so data wins the first conflict.
- At grant, the responder latches the port, operation, word index, `data_wdata` and `data_mbe`, and loads the countdown with `LATENCY-1`.
  - Later changes on the request inputs do not affect the transaction.
  - If the requester drops the request early, the transaction still completes and `resp` still pulses.
- `data_read` and `data_write` both high: treated as a write. `data_rdata` is not updated.
- In BUSY, the counter decrements each cycle. In the cycle the counter is 0:
  - The served port's `resp` is 1.
  - A read presents the array word on its `rdata`.
  - A write commits the enabled byte lanes at the end of that cycle.
  - The FSM returns to `IDLE`.
- Write with `data_mbe`=0: `data_resp` is still pulsed and the array is unchanged.
- `rdata` outputs are registered. Each holds its last read value until that port's next read completes.
- Array contents are not reset.

## Timing
- Request visible in cycle 0 with FSM in `IDLE` → grant at the end of cycle 0 → `resp`=1 in cycle `LATENCY` only.
  - FSM is `IDLE` in cycle `LATENCY+1`.
- Back-to-back throughput is one transaction per `LATENCY+1` cycles.
- A request still high in the cycle after `resp` is a new transaction.
- The synchronous array read is issued in cycle `LATENCY-1` (cycle 0 when `LATENCY`=1). Its data lands in `rdata` for the `resp` cycle.
- Never both `resp` high in the same cycle.
- Reset values:
  - `inst_resp`=0, `data_resp`=0.
  - `inst_rdata`=0, `data_rdata`=0.
  - FSM=`IDLE`, counter=0, `last_grant`=instruction.
- Reset mid-transaction: the transaction is dropped, no write commits, and no `resp` is issued.
  - Requests are first sampled in the cycle after `rst` returns to 1.
- Read-after-write to the same word: a read granted after the write's `resp` returns the new data.

## Structure
- Package `mem_responder_pkg`:
  - `state_e` enum: `IDLE`, `BUSY_I`, `BUSY_D`.
  - `port_e` enum: `PORT_I`, `PORT_D`.
  - Width constant for the latency counter: 4 bits.
- One sub-module `mem_array`:
  - Single-port synchronous word RAM, 2^ADDR_WIDTH × 32.
  - Per-byte write enables.
  - Registered read with 1-cycle latency.
- `mem_responder` holds the FSM, arbiter, counter, transaction latches and output registers.

## Test plan
- **Reset:** `rst`=0 for 3 cycles while `data_read`=1 → both `resp`=0 and both `rdata`=0 throughout. First `data_resp` appears `LATENCY` cycles after the first cycle with `rst`=1.
- **Full write then read:** write 0xDEADBEEF, mbe=4'hF, addr 0x40, then read 0x40 (`LATENCY`=2) → `data_resp` in cycle 2 of each transaction; read returns 0xDEADBEEF. A read of 0x43 also returns 0xDEADBEEF.
- **Byte enables:** word holds 0x11223344; write 0xAABBCCDD with mbe=4'b0101 → readback 0x11BB33DD. A write with mbe=0 still pulses `data_resp`, and the word stays 0x11BB33DD.
- **Simultaneous requests:** `inst_read` and `data_read` held continuously from cycle 0 (`LATENCY`=2) → `data_resp` in cycle 2, `inst_resp` in cycle 5, `data_resp` in cycle 8. `inst_resp` and `data_resp` are never both high in the same cycle.
- **Early drop and aliasing:** `data_write` dropped after cycle 0 → `data_resp` still in cycle `LATENCY` and the write commits. With `ADDR_WIDTH`=10, a write to 0x1000 is read back at 0x0000.
- **Reset mid-operation:** `rst`=0 in cycle 1 of a write with `LATENCY`=3 → no `resp` pulse; a later read of that address returns the prior contents.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder slice.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_e;

    typedef enum logic {
        PORT_I,
        PORT_D
    } port_e;

    localparam int unsigned CNT_W = 4;

    function automatic logic [CNT_W-1:0] lat_load(input int unsigned lat);
        return CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Instruction/data request-response bus between the processor top and the responder.
interface mem_responder_if;

    logic        inst_read;
    logic [31:0] inst_addr;
    logic        inst_resp;
    logic [31:0] inst_rdata;

    logic        data_read;
    logic        data_write;
    logic [3:0]  data_mbe;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_resp;
    logic [31:0] data_rdata;

    modport master (
        output inst_read, inst_addr,
        input  inst_resp, inst_rdata,
        output data_read, data_write, data_mbe, data_addr, data_wdata,
        input  data_resp, data_rdata
    );

    modport slave (
        input  inst_read, inst_addr,
        output inst_resp, inst_rdata,
        input  data_read, data_write, data_mbe, data_addr, data_wdata,
        output data_resp, data_rdata
    );

endinterface

// File: rtl/mem_responder_mem_array.sv
// Single-port synchronous word RAM with per-byte write enables and registered read.
module mem_array #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [3:0]            i_be,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata
);

    logic [31:0] r_mem [2**ADDR_WIDTH];
    logic [31:0] r_rdata;

    // Read-first: a write and read to the same word in one cycle returns the old word.
    always_ff @(posedge i_clk) begin
        for (int unsigned b = 0; b < 4; b++) begin
            if (i_be[b]) begin
                r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Arbitrates the instruction and data ports onto one word array and answers each
// request with a single-cycle resp pulse a fixed LATENCY after grant.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);

    state_e                r_state;
    state_e                w_state_nxt;
    port_e                 r_last_grant;
    port_e                 w_grant;
    logic                  w_grant_en;
    logic                  w_done;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [31:0]           r_wdata;
    logic [3:0]            r_mbe;
    logic [31:0]           r_inst_rdata;
    logic [31:0]           r_data_rdata;

    logic                  w_req_i;
    logic                  w_req_d;
    logic [ADDR_WIDTH-1:0] w_idx_i;
    logic [ADDR_WIDTH-1:0] w_idx_d;
    logic [ADDR_WIDTH-1:0] w_ram_addr;
    logic [3:0]            w_ram_be;
    logic [31:0]           w_ram_q;
    logic                  w_inst_resp;
    logic                  w_data_resp;
    logic                  w_unused_addr_bits;

    assign w_req_i = bus.inst_read;
    assign w_req_d = bus.data_read | bus.data_write;
    assign w_idx_i = bus.inst_addr[ADDR_WIDTH+1:2];
    assign w_idx_d = bus.data_addr[ADDR_WIDTH+1:2];

    assign w_unused_addr_bits = ^{bus.inst_addr[31:ADDR_WIDTH+2], bus.inst_addr[1:0],
                                  bus.data_addr[31:ADDR_WIDTH+2], bus.data_addr[1:0]};

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = r_last_grant;
        w_grant_en  = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req_i && w_req_d) begin
                    w_grant_en = 1'b1;
                    w_grant    = (r_last_grant == PORT_I) ? PORT_D : PORT_I;
                end else if (w_req_i) begin
                    w_grant_en = 1'b1;
                    w_grant    = PORT_I;
                end else if (w_req_d) begin
                    w_grant_en = 1'b1;
                    w_grant    = PORT_D;
                end
                if (w_grant_en) begin
                    w_state_nxt = (w_grant == PORT_I) ? BUSY_I : BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                // Gated by rst so a transaction caught by reset neither pulses nor commits.
                if (rst && r_cnt == '0) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // In IDLE the array reads the winner's word so LATENCY=1 still has data in the resp cycle.
    assign w_ram_addr  = (r_state == IDLE) ? ((w_grant == PORT_I) ? w_idx_i : w_idx_d) : r_idx;
    assign w_inst_resp = w_done && (r_state == BUSY_I);
    assign w_data_resp = w_done && (r_state == BUSY_D);
    assign w_ram_be    = (w_data_resp && r_write) ? r_mbe : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_last_grant <= PORT_I;
            r_write      <= 1'b0;
            r_idx        <= '0;
            r_wdata      <= '0;
            r_mbe        <= '0;
            r_inst_rdata <= '0;
            r_data_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_en) begin
                r_last_grant <= w_grant;
                r_cnt        <= lat_load(LATENCY);
                r_write      <= (w_grant == PORT_D) && bus.data_write;
                r_idx        <= (w_grant == PORT_I) ? w_idx_i : w_idx_d;
                r_wdata      <= bus.data_wdata;
                r_mbe        <= bus.data_mbe;
            end else if (r_state != IDLE && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_inst_resp) begin
                r_inst_rdata <= w_ram_q;
            end
            if (w_data_resp && !r_write) begin
                r_data_rdata <= w_ram_q;
            end
        end
    end

    mem_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem_array (
        .i_clk   (clk),
        .i_addr  (w_ram_addr),
        .i_be    (w_ram_be),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_q)
    );

    assign bus.inst_resp  = w_inst_resp;
    assign bus.data_resp  = w_data_resp;
    assign bus.inst_rdata = w_inst_resp ? w_ram_q : r_inst_rdata;
    assign bus.data_rdata = (w_data_resp && !r_write) ? w_ram_q : r_data_rdata;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: directed vector table, hand sequences and a randomized run
// against a transaction-level reference model.
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int unsigned LAT  = 2;
    localparam int unsigned LAT3 = 3;

    logic clk = 1'b0;
    logic rst;
    logic rst3;
    always #5 clk = ~clk;

    mem_responder_if bus();
    mem_responder_if bus3();

    mem_responder #(.ADDR_WIDTH(10), .LATENCY(LAT)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mem_responder #(.ADDR_WIDTH(10), .LATENCY(LAT3)) u_dut3 (
        .clk (clk),
        .rst (rst3),
        .bus (bus3)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mbe;
        logic        early;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic wr, input logic rd, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] mbe,
                                input logic early, input logic chk, input logic [31:0] exp);
        vec_t v;
        v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wdata;
        v.mbe = mbe; v.early = early; v.chk = chk; v.exp = exp;
        return v;
    endfunction

    vec_t vecs [12];

    // Reference model state
    logic [31:0] ref_mem [1024];
    logic [31:0] m_ird, m_drd;

    task automatic zero_inputs();
        bus.inst_read = 1'b0; bus.inst_addr = '0;
        bus.data_read = 1'b0; bus.data_write = 1'b0; bus.data_mbe = '0;
        bus.data_addr = '0; bus.data_wdata = '0;
    endtask

    // Starts and ends one clock-plus-1 after a rising edge.
    task automatic data_txn(input logic wr, input logic rd, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] mbe,
                            input logic early, input logic chk, input logic [31:0] exp,
                            input string name);
        bus.data_write = wr; bus.data_read = rd; bus.data_addr = addr;
        bus.data_wdata = wdata; bus.data_mbe = mbe;
        for (int c = 0; c <= int'(LAT); c++) begin
            if ((c == 1 && early) || c == int'(LAT)) begin
                bus.data_write = 1'b0; bus.data_read = 1'b0;
                bus.data_addr = addr + 32'h4; bus.data_wdata = ~wdata; bus.data_mbe = ~mbe;
            end
            @(negedge clk);
            check({name, "_data_resp"}, {31'b0, bus.data_resp}, {31'b0, c == int'(LAT)});
            check({name, "_inst_resp"}, {31'b0, bus.inst_resp}, 32'd0);
            if (c == int'(LAT) && chk) check({name, "_rdata"}, bus.data_rdata, exp);
            @(posedge clk); #1;
        end
    endtask

    task automatic inst_txn(input logic [31:0] addr, input logic [31:0] exp, input string name);
        bus.inst_read = 1'b1; bus.inst_addr = addr;
        for (int c = 0; c <= int'(LAT); c++) begin
            if (c == int'(LAT)) begin
                bus.inst_read = 1'b0; bus.inst_addr = ~addr;
            end
            @(negedge clk);
            check({name, "_inst_resp"}, {31'b0, bus.inst_resp}, {31'b0, c == int'(LAT)});
            check({name, "_data_resp"}, {31'b0, bus.data_resp}, 32'd0);
            if (c == int'(LAT)) check({name, "_rdata"}, bus.inst_rdata, exp);
            @(posedge clk); #1;
        end
    endtask

    task automatic reset_dut(input int cycles);
        rst = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("reset_inst_resp", {31'b0, bus.inst_resp}, 32'd0);
            check("reset_data_resp", {31'b0, bus.data_resp}, 32'd0);
            check("reset_inst_rdata", bus.inst_rdata, 32'd0);
            check("reset_data_rdata", bus.data_rdata, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        int          t;
        logic        m_busy;
        port_e       m_port, m_lg, g;
        logic        m_wr;
        logic [9:0]  m_idx;
        logic [31:0] m_wdata;
        logic [3:0]  m_mbe;
        int          m_resp_at;
        logic        e_ir, e_dr, any;
        logic [31:0] e_ird, e_drd, pat;

        zero_inputs();
        bus3.inst_read = 1'b0; bus3.inst_addr = '0;
        bus3.data_read = 1'b0; bus3.data_write = 1'b0; bus3.data_mbe = '0;
        bus3.data_addr = '0; bus3.data_wdata = '0;
        rst  = 1'b0;
        rst3 = 1'b0;

        vecs[0]  = mk(1, 0, 32'h40,   32'hDEADBEEF, 4'hF, 0, 0, 32'h0);
        vecs[1]  = mk(0, 1, 32'h40,   32'h0,        4'h0, 0, 1, 32'hDEADBEEF);
        vecs[2]  = mk(0, 1, 32'h43,   32'h0,        4'h0, 0, 1, 32'hDEADBEEF);
        vecs[3]  = mk(1, 0, 32'h80,   32'h11223344, 4'hF, 0, 1, 32'hDEADBEEF);
        vecs[4]  = mk(1, 0, 32'h80,   32'hAABBCCDD, 4'h5, 0, 1, 32'hDEADBEEF);
        vecs[5]  = mk(0, 1, 32'h80,   32'h0,        4'h0, 0, 1, 32'h11BB33DD);
        vecs[6]  = mk(1, 0, 32'h80,   32'hFFFFFFFF, 4'h0, 0, 1, 32'h11BB33DD);
        vecs[7]  = mk(0, 1, 32'h80,   32'h0,        4'h0, 0, 1, 32'h11BB33DD);
        vecs[8]  = mk(1, 1, 32'h84,   32'h00000055, 4'hF, 0, 1, 32'h11BB33DD);
        vecs[9]  = mk(0, 1, 32'h84,   32'h0,        4'h0, 0, 1, 32'h00000055);
        vecs[10] = mk(1, 0, 32'h1000, 32'hCAFEF00D, 4'hF, 1, 1, 32'h00000055);
        vecs[11] = mk(0, 1, 32'h0,    32'h0,        4'h0, 0, 1, 32'hCAFEF00D);

        // Reset held 3 cycles with a data read pending
        bus.data_read = 1'b1;
        reset_dut(3);
        for (int c = 0; c <= int'(LAT); c++) begin
            if (c == int'(LAT)) bus.data_read = 1'b0;
            @(negedge clk);
            check("rst_release_data_resp", {31'b0, bus.data_resp}, {31'b0, c == int'(LAT)});
            check("rst_release_inst_resp", {31'b0, bus.inst_resp}, 32'd0);
            @(posedge clk); #1;
        end

        for (int i = 0; i < 12; i++) begin
            data_txn(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].mbe,
                     vecs[i].early, vecs[i].chk, vecs[i].exp, $sformatf("vec%0d", i));
        end

        inst_txn(32'h40, 32'hDEADBEEF, "inst_rd");

        // Both ports held continuously: data, inst, data
        bus.inst_read = 1'b1; bus.inst_addr = 32'h80;
        bus.data_read = 1'b1; bus.data_addr = 32'h84;
        for (int c = 0; c <= 8; c++) begin
            if (c == 8) begin
                bus.inst_read = 1'b0; bus.data_read = 1'b0;
            end
            @(negedge clk);
            check($sformatf("simul_inst_resp_c%0d", c), {31'b0, bus.inst_resp}, {31'b0, c == 5});
            check($sformatf("simul_data_resp_c%0d", c), {31'b0, bus.data_resp},
                  {31'b0, (c == 2 || c == 8)});
            if (c == 5) check("simul_inst_rdata", bus.inst_rdata, 32'h11BB33DD);
            if (c == 2 || c == 8) check("simul_data_rdata", bus.data_rdata, 32'h00000055);
            @(posedge clk); #1;
        end

        // Prefill words 0..15 so the random phase has known contents
        for (int k = 0; k < 16; k++) begin
            pat = $urandom;
            data_txn(1, 0, 32'(k * 4), pat, 4'hF, 0, 0, 32'h0, "prefill");
            ref_mem[k] = pat;
        end

        zero_inputs();
        reset_dut(2);

        m_busy = 1'b0; m_lg = PORT_I; m_port = PORT_I; m_wr = 1'b0;
        m_idx = '0; m_wdata = '0; m_mbe = '0; m_resp_at = -1;
        m_ird = '0; m_drd = '0;
        for (t = 0; t < 600; t++) begin
            @(negedge clk);
            e_ir  = m_busy && t == m_resp_at && m_port == PORT_I;
            e_dr  = m_busy && t == m_resp_at && m_port == PORT_D;
            e_ird = e_ir ? ref_mem[m_idx] : m_ird;
            e_drd = (e_dr && !m_wr) ? ref_mem[m_idx] : m_drd;
            check("rand_inst_resp", {31'b0, bus.inst_resp}, {31'b0, e_ir});
            check("rand_data_resp", {31'b0, bus.data_resp}, {31'b0, e_dr});
            check("rand_inst_rdata", bus.inst_rdata, e_ird);
            check("rand_data_rdata", bus.data_rdata, e_drd);
            check("rand_resp_exclusive", {31'b0, bus.inst_resp & bus.data_resp}, 32'd0);

            // Requesters: on completion either drop or chain a new request
            if (bus.inst_read ? (e_ir && $urandom_range(0, 1) == 0) : 1'b0) begin
                bus.inst_read = 1'b0;
            end else if ((bus.inst_read && e_ir) || (!bus.inst_read && $urandom_range(0, 9) < 4)) begin
                bus.inst_read = 1'b1;
                bus.inst_addr = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 15) << 2)
                                | 32'($urandom_range(0, 3));
            end
            if ((bus.data_read | bus.data_write) ? (e_dr && $urandom_range(0, 1) == 0) : 1'b0) begin
                bus.data_read = 1'b0; bus.data_write = 1'b0;
            end else if (((bus.data_read | bus.data_write) && e_dr) ||
                         (!(bus.data_read | bus.data_write) && $urandom_range(0, 9) < 4)) begin
                case ($urandom_range(0, 2))
                    0:       begin bus.data_read = 1'b1; bus.data_write = 1'b0; end
                    1:       begin bus.data_read = 1'b0; bus.data_write = 1'b1; end
                    default: begin bus.data_read = 1'b1; bus.data_write = 1'b1; end
                endcase
                bus.data_addr  = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 15) << 2)
                                 | 32'($urandom_range(0, 3));
                bus.data_wdata = $urandom;
                bus.data_mbe   = 4'($urandom_range(0, 15));
            end

            // Model end-of-cycle update using the inputs the DUT samples at the next edge
            if (m_busy && t == m_resp_at) begin
                m_ird = e_ird;
                m_drd = e_drd;
                if (e_dr && m_wr) begin
                    for (int b = 0; b < 4; b++)
                        if (m_mbe[b]) ref_mem[m_idx][8*b +: 8] = m_wdata[8*b +: 8];
                end
                m_busy = 1'b0;
            end else if (!m_busy) begin
                any = 1'b1;
                g   = PORT_I;
                if (bus.inst_read && (bus.data_read | bus.data_write))
                    g = (m_lg == PORT_I) ? PORT_D : PORT_I;
                else if (bus.inst_read)
                    g = PORT_I;
                else if (bus.data_read | bus.data_write)
                    g = PORT_D;
                else
                    any = 1'b0;
                if (any) begin
                    m_busy    = 1'b1;
                    m_port    = g;
                    m_lg      = g;
                    m_resp_at = t + int'(LAT);
                    m_wr      = (g == PORT_D) && bus.data_write;
                    m_idx     = (g == PORT_I) ? bus.inst_addr[11:2] : bus.data_addr[11:2];
                    m_wdata   = bus.data_wdata;
                    m_mbe     = bus.data_mbe;
                end
            end
            @(posedge clk);
        end
        #1;
        zero_inputs();
        repeat (LAT + 2) @(posedge clk);
        #1;

        // LATENCY=3 instance: reset mid-write drops the transaction
        rst3 = 1'b1;
        bus3.data_write = 1'b1; bus3.data_addr = 32'h20; bus3.data_wdata = 32'h12345678;
        bus3.data_mbe = 4'hF;
        for (int c = 0; c <= int'(LAT3); c++) begin
            if (c == int'(LAT3)) bus3.data_write = 1'b0;
            @(negedge clk);
            check("l3_wr_data_resp", {31'b0, bus3.data_resp}, {31'b0, c == int'(LAT3)});
            @(posedge clk); #1;
        end
        bus3.data_write = 1'b1; bus3.data_wdata = 32'hFFFFFFFF;
        for (int c = 0; c <= 5; c++) begin
            if (c == 1) rst3 = 1'b0;
            if (c == 2) bus3.data_write = 1'b0;
            if (c == 3) rst3 = 1'b1;
            @(negedge clk);
            check($sformatf("l3_midrst_data_resp_c%0d", c), {31'b0, bus3.data_resp}, 32'd0);
            check($sformatf("l3_midrst_inst_resp_c%0d", c), {31'b0, bus3.inst_resp}, 32'd0);
            @(posedge clk); #1;
        end
        bus3.data_read = 1'b1; bus3.data_addr = 32'h20;
        for (int c = 0; c <= int'(LAT3); c++) begin
            if (c == int'(LAT3)) bus3.data_read = 1'b0;
            @(negedge clk);
            check("l3_rd_data_resp", {31'b0, bus3.data_resp}, {31'b0, c == int'(LAT3)});
            if (c == int'(LAT3)) check("l3_rd_rdata", bus3.data_rdata, 32'h12345678);
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
